sram_mem_ctrl: RTL

SRAM_MEM_CTRL -- requirements
Module: sram_mem_ctrl

---
 rtl/sram_mem_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/sram_mem_ctrl.sv
// Word-wide load/store controller that splits each 32-bit access into two
// 16-bit SRAM accesses (low halfword, then high halfword).
module sram_mem_ctrl #(
  parameter logic [31:0] BASE_ADDR     = 32'd1024,
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic        sram_we_n,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [16:0] word_addr_q, word_addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] read_data_q, read_data_d;
  logic [31:0] offset;
  logic        req;

  assign req    = mem_read | mem_write;
  assign offset = address - BASE_ADDR;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    word_addr_d = word_addr_q;
    wdata_d     = wdata_q;
    read_data_d = read_data_q;

    case (state_q)
      IDLE: begin
        if (req) begin
          write_d     = mem_write & ~mem_read;
          word_addr_d = 17'(offset >> 2);
          wdata_d     = write_data;
          cnt_d       = '0;
          state_d     = LO;
        end
      end
      LO: begin
        if (cnt_q == LAST_CNT) begin
          if (!write_q) read_data_d[15:0] = sram_dq_in;
          cnt_d   = '0;
          state_d = HI;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      HI: begin
        if (cnt_q == LAST_CNT) begin
          if (!write_q) read_data_d[31:16] = sram_dq_in;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    // Reset folded into the next-state path; it aborts LO/HI immediately.
    if (rst) begin
      state_d     = IDLE;
      cnt_d       = '0;
      write_d     = 1'b0;
      read_data_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    state_q     <= state_d;
    cnt_q       <= cnt_d;
    write_q     <= write_d;
    word_addr_q <= word_addr_d;
    wdata_q     <= wdata_d;
    read_data_q <= read_data_d;
  end

  always_comb begin
    sram_addr   = '0;
    sram_we_n   = 1'b1;
    sram_dq_oe  = 1'b0;
    sram_dq_out = '0;
    ready       = 1'b0;

    case (state_q)
      IDLE: ready = ~req;
      LO: begin
        sram_addr = {word_addr_q, 1'b0};
        if (write_q) begin
          sram_we_n   = 1'b0;
          sram_dq_oe  = 1'b1;
          sram_dq_out = wdata_q[15:0];
        end
      end
      HI: begin
        sram_addr = {word_addr_q, 1'b1};
        if (write_q) begin
          sram_we_n   = 1'b0;
          sram_dq_oe  = 1'b1;
          sram_dq_out = wdata_q[31:16];
        end
      end
      default: ready = 1'b1;
    endcase

    if (rst) ready = ~req;
  end

  assign read_data = read_data_q;

endmodule
